ram_loader: RTL and testbench

// Upstream programming stage for the 16x8 ram block. Accepts a byte stream over a valid/ready handshake and

---
 rtl/ram_loader_pkg.sv | 33 +++
 rtl/ram_loader_strobe_timer.sv | 41 ++++
 rtl/ram_loader.sv | 189 ++++++++++++++++++
 tb/tb_ram_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types and constants for the ram_loader programming stage.
//   DEF_*        default geometry and write-pulse length
//   STROBE_ON/OFF  levels of the active-low RAM strobes
//   state_e      loader FSM states
//   cnt_width()  width of the write-pulse down-counter
package ram_loader_pkg;

   localparam int unsigned DEF_ADDR_W   = 4;
   localparam int unsigned DEF_DATA_W   = 8;
   localparam int unsigned DEF_DEPTH    = 16;
   localparam int unsigned DEF_WR_PULSE = 2;

   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD_WAIT,
      ST_SETUP,
      ST_WRITE,
      ST_HOLD,
      ST_RD_ADDR,
      ST_RD_STROBE,
      ST_RD_SAMPLE,
      ST_FINISH
   } state_e;

   // Counter holds WR_PULSE-1 at most; keep at least one bit.
   function automatic int unsigned cnt_width(input int unsigned pulse);
      return (pulse < 2) ? 1 : $clog2(pulse);
   endfunction

endpackage

// File: rtl/ram_loader_strobe_timer.sv
// ram_strobe_timer: loadable down-counter timing the write_bar low phase.
//   clk, rst    clock, async active-high reset
//   load        load load_val this cycle (overrides counting)
//   load_val    cycles remaining minus one
//   expired_c   counter at zero (combinational)
module ram_strobe_timer
   import ram_loader_pkg::*;
#(
   parameter int unsigned CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load has priority; otherwise count down and stick at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/ram_loader.sv
// ram_loader: loads a byte stream into RAM addresses 0..len_eff-1, reads it back
// and compares XOR checksums.
//   clk, rst              clock, async active-high reset
//   start, len            begin a load of min(len, DEPTH) bytes (IDLE only)
//   byte_in/valid/ready   input byte stream handshake
//   ram_*                 RAM address/data/strobes (strobes active low), ram_data_out read data
//   busy, done, verify_ok status; verify_ok valid from done until next accepted start
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned WR_PULSE = DEF_WR_PULSE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   output logic              ram_write_bar,
   output logic              ram_read_bar,
   output logic              ram_output_enable,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy,
   output logic              done,
   output logic              verify_ok
);

   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam int unsigned CNT_W = cnt_width(WR_PULSE);

   state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] wsum_q, wsum_d;
   logic [DATA_W-1:0] rsum_q, rsum_d;
   logic              write_bar_q, write_bar_d;
   logic              read_bar_q, read_bar_d;
   logic              oe_q, oe_d;
   logic              byte_ready_q, byte_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              verify_q, verify_d;

   logic [LEN_W-1:0]  len_eff_c;
   logic              accept_c;
   logic              at_last_c;
   logic              timer_load_c;
   logic              timer_expired_c;

   assign len_eff_c    = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
   assign accept_c     = (state_q == ST_LOAD_WAIT) && byte_valid && byte_ready_q;
   assign at_last_c    = (addr_q == last_q);
   assign timer_load_c = (state_q == ST_SETUP);

   ram_strobe_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load_c),
      .load_val  (CNT_W'(WR_PULSE - 1)),
      .expired_c (timer_expired_c)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (start) state_d = (len_eff_c == '0) ? ST_FINISH : ST_LOAD_WAIT;
         ST_LOAD_WAIT: if (accept_c) state_d = ST_SETUP;
         ST_SETUP:     state_d = ST_WRITE;
         ST_WRITE:     if (timer_expired_c) state_d = ST_HOLD;
         ST_HOLD:      state_d = at_last_c ? ST_RD_ADDR : ST_LOAD_WAIT;
         ST_RD_ADDR:   state_d = ST_RD_STROBE;
         ST_RD_STROBE: state_d = ST_RD_SAMPLE;
         ST_RD_SAMPLE: state_d = at_last_c ? ST_FINISH : ST_RD_ADDR;
         ST_FINISH:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Output / datapath next values; strobes and byte_ready follow the next state
   // so their registered copies line up with the state they belong to.
   always_comb begin
      addr_d       = addr_q;
      last_d       = last_q;
      data_d       = data_q;
      wsum_d       = wsum_q;
      rsum_d       = rsum_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      verify_d     = verify_q;
      write_bar_d  = (state_d == ST_WRITE) ? STROBE_ON : STROBE_OFF;
      read_bar_d   = (state_d == ST_RD_STROBE) ? STROBE_ON : STROBE_OFF;
      oe_d         = ((state_d == ST_RD_STROBE) || (state_d == ST_RD_SAMPLE)) ? STROBE_ON : STROBE_OFF;
      byte_ready_d = (state_d == ST_LOAD_WAIT);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d   = '0;
               last_d   = ADDR_W'(len_eff_c - LEN_W'(1));
               wsum_d   = '0;
               rsum_d   = '0;
               busy_d   = 1'b1;
               verify_d = 1'b0;
            end
         end
         ST_LOAD_WAIT: begin
            if (accept_c) begin
               data_d = byte_in;
               wsum_d = wsum_q ^ byte_in;
            end
         end
         ST_HOLD: begin
            addr_d = at_last_c ? '0 : addr_q + ADDR_W'(1);
         end
         ST_RD_SAMPLE: begin
            rsum_d = rsum_q ^ ram_data_out;
            if (!at_last_c) addr_d = addr_q + ADDR_W'(1);
         end
         ST_FINISH: begin
            verify_d = (wsum_q == rsum_q);
            done_d   = 1'b1;
            busy_d   = 1'b0;
         end
         default: ;
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q       <= '0;
         last_q       <= '0;
         data_q       <= '0;
         wsum_q       <= '0;
         rsum_q       <= '0;
         write_bar_q  <= STROBE_OFF;
         read_bar_q   <= STROBE_OFF;
         oe_q         <= STROBE_OFF;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         verify_q     <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         last_q       <= last_d;
         data_q       <= data_d;
         wsum_q       <= wsum_d;
         rsum_q       <= rsum_d;
         write_bar_q  <= write_bar_d;
         read_bar_q   <= read_bar_d;
         oe_q         <= oe_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         verify_q     <= verify_d;
      end
   end

   assign byte_ready        = byte_ready_q;
   assign ram_address       = addr_q;
   assign ram_data_in       = data_q;
   assign ram_write_bar     = write_bar_q;
   assign ram_read_bar      = read_bar_q;
   assign ram_output_enable = oe_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign verify_ok         = verify_q;

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed bench for ram_loader with a behavioural 16x8 RAM attached.
module tb_ram_loader;
   import ram_loader_pkg::*;

   localparam int unsigned AW  = DEF_ADDR_W;
   localparam int unsigned DW  = DEF_DATA_W;
   localparam int unsigned DEP = DEF_DEPTH;
   localparam int unsigned WRP = DEF_WR_PULSE;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   len;
   logic [DW-1:0] byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic          ram_write_bar;
   logic          ram_read_bar;
   logic          ram_output_enable;
   logic [DW-1:0] ram_data_out;
   logic          busy;
   logic          done;
   logic          verify_ok;

   always #5 clk = ~clk;

   ram_loader #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .DEPTH    (DEP),
      .WR_PULSE (WRP)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .len               (len),
      .byte_in           (byte_in),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready),
      .ram_address       (ram_address),
      .ram_data_in       (ram_data_in),
      .ram_write_bar     (ram_write_bar),
      .ram_read_bar      (ram_read_bar),
      .ram_output_enable (ram_output_enable),
      .ram_data_out      (ram_data_out),
      .busy              (busy),
      .done              (done),
      .verify_ok         (verify_ok)
   );

   // Behavioural RAM plus write counter, strobe activity and optional bit-flip of mem[2]
   logic [DW-1:0] mem [DEP];
   logic [DW-1:0] src [20];
   logic          cnt_clr = 1'b0;
   logic          corrupt_arm = 1'b0;
   logic          corrupted = 1'b0;
   logic          wb_prev = 1'b1;
   logic          strobe_seen = 1'b0;
   logic [AW-1:0] last_wr_addr = '0;
   int            wr_count = 0;

   assign ram_data_out = (ram_output_enable == STROBE_ON) ? mem[ram_address] : '0;

   always @(posedge clk) begin
      if (ram_write_bar == STROBE_ON) begin
         mem[ram_address] <= ram_data_in;
         last_wr_addr     <= ram_address;
      end
      if (!corrupt_arm) begin
         corrupted <= 1'b0;
      end else if (!corrupted && ram_read_bar == STROBE_ON) begin
         mem[2]    <= mem[2] ^ 8'h04;
         corrupted <= 1'b1;
      end
      if (cnt_clr) begin
         wr_count    <= 0;
         strobe_seen <= 1'b0;
      end else begin
         if (ram_write_bar == STROBE_ON && wb_prev) wr_count <= wr_count + 1;
         if (!ram_write_bar || !ram_read_bar || !ram_output_enable) strobe_seen <= 1'b1;
      end
      wb_prev <= ram_write_bar;
   end

   int vectors = 0;
   int errs    = 0;
   int chk_errs = 0;

   // Per-cycle protocol checker
   logic          wl_prev = 1'b0;
   logic [AW-1:0] a_prev = '0;
   logic [DW-1:0] d_prev = '0;
   always @(negedge clk) begin
      if (rst) begin
         wl_prev = 1'b0;
      end else begin
         if (!ram_write_bar && !ram_read_bar) begin
            chk_errs++;
            $display("FAIL strobe_overlap: write_bar=%b read_bar=%b required not both 0", ram_write_bar, ram_read_bar);
         end
         if (!ram_write_bar && wl_prev && (ram_address !== a_prev || ram_data_in !== d_prev)) begin
            chk_errs++;
            $display("FAIL write_stable: addr=%0h data=%0h required addr=%0h data=%0h",
                     ram_address, ram_data_in, a_prev, d_prev);
         end
         wl_prev = !ram_write_bar;
         a_prev  = ram_address;
         d_prev  = ram_data_in;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   // Start a load at this negedge and feed src[] with a gap of (idx % gap_mod) idle
   // cycles before each byte; optionally pulse start again at cycle poke_at.
   task automatic run_load(input int n, input int gap_mod, input int poke_at,
                           output int cycles, output logic got_done);
      int   idx;
      int   gap;
      logic will_acc;
      idx      = 0;
      gap      = 0;
      cycles   = 0;
      got_done = 1'b0;
      start      = 1'b1;
      len        = (AW+1)'(n);
      byte_valid = (n > 0);
      byte_in    = src[0];
      will_acc   = byte_ready && byte_valid;
      for (int c = 0; c < 2000 && !got_done; c++) begin
         @(negedge clk);
         cycles++;
         start = (cycles == poke_at);
         if (cycles == poke_at) len = (AW+1)'(3);
         if (cycles == 1) check("busy_after_start", 32'(busy), 32'd1);
         if (done) begin
            got_done = 1'b1;
         end else begin
            if (will_acc) begin
               idx++;
               gap = (gap_mod > 0) ? (idx % gap_mod) : 0;
            end else if (gap > 0) begin
               gap--;
            end
            byte_valid = (gap == 0) && (idx < n);
            byte_in    = (idx < 20) ? src[idx] : '0;
            will_acc   = byte_ready && byte_valid;
         end
      end
      start      = 1'b0;
      byte_valid = 1'b0;
      check("done_seen", 32'(got_done), 32'd1);
   endtask

   int   cyc;
   logic gd;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      len        = '0;
      byte_in    = '0;
      byte_valid = 1'b0;
      foreach (src[i]) src[i] = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_write_bar", 32'(ram_write_bar), 32'd1);
      check("rst_read_bar",  32'(ram_read_bar), 32'd1);
      check("rst_oe",        32'(ram_output_enable), 32'd1);
      check("rst_address",   32'(ram_address), 32'd0);
      check("rst_data_in",   32'(ram_data_in), 32'd0);
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_done",      32'(done), 32'd0);
      check("rst_verify_ok", 32'(verify_ok), 32'd0);
      rst = 1'b0;

      // Async reset while write_bar is low
      @(negedge clk);
      start      = 1'b1;
      len        = (AW+1)'(1);
      byte_valid = 1'b1;
      byte_in    = 8'h55;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 10 && ram_write_bar; c++) @(negedge clk);
      check("midwrite_write_bar_low", 32'(ram_write_bar), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("midwrite_rst_write_bar", 32'(ram_write_bar), 32'd1);
      check("midwrite_rst_busy",      32'(busy), 32'd0);
      check("midwrite_rst_byte_ready", 32'(byte_ready), 32'd0);
      check("midwrite_rst_data_in",   32'(ram_data_in), 32'd0);
      byte_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // len=4, back-to-back bytes
      src[0] = 8'h0A; src[1] = 8'h0B; src[2] = 8'h0C; src[3] = 8'h0D;
      clear_counts();
      run_load(4, 0, -1, cyc, gd);
      check("len4_latency", 32'(cyc), 32'(4*(WRP+2+1) + 4*3 + 2));
      check("len4_verify_ok", 32'(verify_ok), 32'd1);
      check("len4_busy_at_done", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) check($sformatf("len4_mem_%0d", i), 32'(mem[i]), 32'(src[i]));
      @(negedge clk);
      check("len4_done_one_cycle", 32'(done), 32'd0);
      check("len4_verify_held", 32'(verify_ok), 32'd1);

      // len=16 with 0-3 cycle gaps and a start pulse while busy
      for (int i = 0; i < 20; i++) src[i] = 8'(8'h31 + i * 7);
      clear_counts();
      run_load(16, 4, 10, cyc, gd);
      check("len16_verify_ok", 32'(verify_ok), 32'd1);
      check("len16_writes", 32'(wr_count), 32'd16);
      check("len16_last_addr", 32'(last_wr_addr), 32'd15);
      for (int i = 0; i < 16; i++) check($sformatf("len16_mem_%0d", i), 32'(mem[i]), 32'(src[i]));

      // len=0
      clear_counts();
      run_load(0, 0, -1, cyc, gd);
      check("len0_latency", 32'(cyc), 32'd2);
      check("len0_verify_ok", 32'(verify_ok), 32'd1);
      check("len0_no_strobe", 32'(strobe_seen), 32'd0);

      // len=20 clamps to 16
      for (int i = 0; i < 20; i++) src[i] = 8'(8'hC5 ^ (i * 3));
      clear_counts();
      run_load(20, 0, -1, cyc, gd);
      check("len20_writes", 32'(wr_count), 32'd16);
      check("len20_last_addr", 32'(last_wr_addr), 32'd15);
      check("len20_mem_0", 32'(mem[0]), 32'(src[0]));
      check("len20_mem_15", 32'(mem[15]), 32'(src[15]));
      check("len20_verify_ok", 32'(verify_ok), 32'd1);

      // Bit flip in mem[2] after load, before its read-back
      src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
      clear_counts();
      corrupt_arm = 1'b1;
      run_load(4, 0, -1, cyc, gd);
      check("corrupt_verify_ok", 32'(verify_ok), 32'd0);
      check("corrupt_mem_2", 32'(mem[2]), 32'h37);
      corrupt_arm = 1'b0;

      // Verify recovers on the next clean load
      src[0] = 8'h5A; src[1] = 8'hA5;
      clear_counts();
      run_load(2, 2, -1, cyc, gd);
      check("recover_verify_ok", 32'(verify_ok), 32'd1);
      check("recover_writes", 32'(wr_count), 32'd2);

      repeat (2) @(negedge clk);
      check("protocol_checker", 32'(chk_errs), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
